// File: rtl/bsdeser.sv
// bsdeser: bit-serial to parallel collector behind the modmul stage.
// Collects LSB-first LEN-bit words framed by isync and queues them in a
// 2-entry valid/ready FIFO. Sticky flags report dropped words (overrun) and
// sync pulses that cut a word short (frame_err).
// Optional feature macro: BSDESER_CANON_EN -- adds a register stage that
// reduces each completed word into [0, P) with P = 2^LEN - 3.
module bsdeser #(
   parameter int LEN = 22
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           is,
   input  logic           isync,
   output logic [LEN-1:0] q,
   output logic           qvalid,
   input  logic           qready,
   output logic           overrun,
   output logic           frame_err
);

   localparam int CW = $clog2(LEN);
   localparam logic [CW-1:0] LASTBIT = CW'(LEN - 1);

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_COLLECT = 1'b1
   } state_t;

   // collector state
   state_t         state_r, state_n_s;
   logic [CW-1:0]  cnt_r, cnt_n_s;
   logic [LEN-1:0] sh_r, sh_n_s;
   logic           done_s;
   logic           ferr_set_s;

   // FIFO state
   logic [LEN-1:0] head_r, head_n_s;
   logic [LEN-1:0] tail_r, tail_n_s;
   logic [1:0]     fcnt_r, fcnt_n_s;
   logic           qvalid_r;
   logic           ovr_r, ovr_set_s;
   logic           ferr_r;
   logic           push_s;
   logic           pop_s;
   logic [LEN-1:0] push_data_s;

   // Collector state register and shift register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
         cnt_r   <= CW'(0);
         sh_r    <= {LEN{1'b0}};
      end else begin
         state_r <= state_n_s;
         cnt_r   <= cnt_n_s;
         sh_r    <= sh_n_s;
      end
   end

   // Collector next state: start on sync, shift bits in, complete at LEN-1
   always_comb begin
      state_n_s  = state_r;
      cnt_n_s    = cnt_r;
      sh_n_s     = sh_r;
      done_s     = 1'b0;
      ferr_set_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (isync) begin
               sh_n_s    = {{(LEN-1){1'b0}}, is};
               cnt_n_s   = CW'(1);
               state_n_s = ST_COLLECT;
            end else begin
               state_n_s = ST_IDLE;
            end
         end
         ST_COLLECT: begin
            if (isync) begin
               // a sync inside a word abandons the partial word and restarts
               ferr_set_s = 1'b1;
               sh_n_s     = {{(LEN-1){1'b0}}, is};
               cnt_n_s    = CW'(1);
               state_n_s  = ST_COLLECT;
            end else begin
               sh_n_s[cnt_r] = is;
               if (cnt_r == LASTBIT) begin
                  done_s    = 1'b1;
                  cnt_n_s   = CW'(0);
                  state_n_s = ST_IDLE;
               end else begin
                  cnt_n_s   = cnt_r + CW'(1);
                  state_n_s = ST_COLLECT;
               end
            end
         end
         default: begin
            state_n_s = ST_IDLE;
            cnt_n_s   = CW'(0);
            sh_n_s    = {LEN{1'b0}};
         end
      endcase
   end

`ifdef BSDESER_CANON_EN
   localparam logic [LEN-1:0] PMOD = {{(LEN-2){1'b1}}, 2'b01};

   logic           cvalid_r;
   logic [LEN-1:0] cword_r;

   // Reduce a collected word into [0, P); only P..P+2 need the subtraction
   function automatic logic [LEN-1:0] canon(input logic [LEN-1:0] w);
      logic [LEN-1:0] r;
      if (w >= PMOD) begin
         r = w - PMOD;
      end else begin
         r = w;
      end
      return r;
   endfunction

   // Canonicalisation register stage between collector and FIFO
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cvalid_r <= 1'b0;
         cword_r  <= {LEN{1'b0}};
      end else begin
         cvalid_r <= done_s;
         if (done_s) begin
            cword_r <= canon(sh_n_s);
         end else begin
            cword_r <= cword_r;
         end
      end
   end

   assign push_s      = cvalid_r;
   assign push_data_s = cword_r;
`else
   assign push_s      = done_s;
   assign push_data_s = sh_n_s;
`endif

   assign pop_s = qvalid_r & qready;

   // FIFO next state: in-order 2 entries, head drives q, drop when full
   always_comb begin
      head_n_s  = head_r;
      tail_n_s  = tail_r;
      fcnt_n_s  = fcnt_r;
      ovr_set_s = 1'b0;
      case (fcnt_r)
         2'd0: begin
            if (push_s) begin
               head_n_s = push_data_s;
               fcnt_n_s = 2'd1;
            end else begin
               fcnt_n_s = 2'd0;
            end
         end
         2'd1: begin
            if (push_s && pop_s) begin
               head_n_s = push_data_s;
            end else if (push_s) begin
               tail_n_s = push_data_s;
               fcnt_n_s = 2'd2;
            end else if (pop_s) begin
               fcnt_n_s = 2'd0;
            end else begin
               fcnt_n_s = 2'd1;
            end
         end
         2'd2: begin
            if (push_s && pop_s) begin
               head_n_s = tail_r;
               tail_n_s = push_data_s;
            end else if (push_s) begin
               ovr_set_s = 1'b1;
            end else if (pop_s) begin
               head_n_s = tail_r;
               fcnt_n_s = 2'd1;
            end else begin
               fcnt_n_s = 2'd2;
            end
         end
         default: begin
            fcnt_n_s = 2'd0;
         end
      endcase
   end

   // FIFO storage, registered valid and sticky status flags
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_r   <= {LEN{1'b0}};
         tail_r   <= {LEN{1'b0}};
         fcnt_r   <= 2'd0;
         qvalid_r <= 1'b0;
         ovr_r    <= 1'b0;
         ferr_r   <= 1'b0;
      end else begin
         head_r   <= head_n_s;
         tail_r   <= tail_n_s;
         fcnt_r   <= fcnt_n_s;
         qvalid_r <= (fcnt_n_s != 2'd0);
         ovr_r    <= ovr_r | ovr_set_s;
         ferr_r   <= ferr_r | ferr_set_s;
      end
   end

   assign q         = head_r;
   assign qvalid    = qvalid_r;
   assign overrun   = ovr_r;
   assign frame_err = ferr_r;

endmodule

// File: tb/tb_bsdeser.sv
// tb_bsdeser: scoreboard bench for bsdeser. Expected words are queued as
// stimulus is driven and compared when the consumer side accepts a word.
module tb_bsdeser;

   localparam int LEN = 22;
   localparam logic [31:0] PVAL = (32'd1 << LEN) - 32'd3;
`ifdef BSDESER_CANON_EN
   localparam bit CANON = 1'b1;
`else
   localparam bit CANON = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           reset;
   logic           is;
   logic           isync;
   logic           qready;
   logic [LEN-1:0] q;
   logic           qvalid;
   logic           overrun;
   logic           frame_err;

   int          total = 0;
   int          bad = 0;
   logic [31:0] expq[$];

   bsdeser #(.LEN(LEN)) dut (
      .clk       (clk),
      .reset     (reset),
      .is        (is),
      .isync     (isync),
      .q         (q),
      .qvalid    (qvalid),
      .qready    (qready),
      .overrun   (overrun),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [31:0] w);
      if (CANON && w >= PVAL) return w - PVAL;
      return w;
   endfunction

   // consumer side: every accepted word must match the scoreboard head
   always @(negedge clk) begin
      if (reset && qvalid && qready) begin
         if (expq.size() == 0) begin
            chk_val("sb_extra_word", 32'(expq.size()), 32'd1);
         end else begin
            chk_val("q_word", 32'(q), expq.pop_front());
         end
      end
   end

   task automatic tick();
      isync = 1'b0;
      is    = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic send_bits(input logic [31:0] w, input int n, input bit rdy_last);
      for (int i = 0; i < n; i++) begin
         isync = (i == 0);
         is    = w[i];
         if (rdy_last && i == n - 1) qready = 1'b1;
         @(posedge clk);
         #1;
      end
      isync = 1'b0;
      is    = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && expq.size() != 0; i++) tick();
      chk_val("drain", 32'(expq.size()), 32'd0);
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
   endtask

   initial begin
      #2000000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset  = 1'b0;
      is     = 1'b0;
      isync  = 1'b0;
      qready = 1'b0;
      tick();
      tick();
      chk_val("rst_qvalid", 32'(qvalid), 32'd0);
      chk_val("rst_q", 32'(q), 32'd0);
      chk_val("rst_overrun", 32'(overrun), 32'd0);
      chk_val("rst_frame_err", 32'(frame_err), 32'd0);
      reset = 1'b1;
      tick();

      // single word, latency and one-cycle valid
      qready = 1'b1;
      expq.push_back(model(32'h155555));
      send_bits(32'h155555, LEN, 1'b0);
`ifdef BSDESER_CANON_EN
      chk_val("lat_early", 32'(qvalid), 32'd0);
      tick();
`endif
      chk_val("lat_valid", 32'(qvalid), 32'd1);
      tick();
      chk_val("lat_one_cycle", 32'(qvalid), 32'd0);
      drain();
      chk_val("t1_overrun", 32'(overrun), 32'd0);
      chk_val("t1_frame_err", 32'(frame_err), 32'd0);

      // three back-to-back words into a stalled consumer: third dropped
      qready = 1'b0;
      expq.push_back(model(32'd1));
      expq.push_back(model(32'd2));
      send_bits(32'd1, LEN, 1'b0);
      send_bits(32'd2, LEN, 1'b0);
      send_bits(32'd3, LEN, 1'b0);
      tick();
      tick();
      chk_val("t2_overrun", 32'(overrun), 32'd1);
      chk_val("t2_qvalid", 32'(qvalid), 32'd1);
      chk_val("t2_head", 32'(q), 32'd1);
      qready = 1'b1;
      drain();
      chk_val("t2_frame_err", 32'(frame_err), 32'd0);

      // full buffer, pop coincides with third completion: nothing dropped
      pulse_reset();
      qready = 1'b0;
      expq.push_back(model(32'd4));
      expq.push_back(model(32'd5));
      expq.push_back(model(32'd6));
      send_bits(32'd4, LEN, 1'b0);
      send_bits(32'd5, LEN, 1'b0);
      send_bits(32'd6, LEN, 1'b1);
      drain();
      chk_val("t3_overrun", 32'(overrun), 32'd0);

      // sync cuts a word at bit 10, then a full word
      pulse_reset();
      qready = 1'b1;
      send_bits(32'h2AB, 10, 1'b0);
      expq.push_back(model(32'h3FFFFF));
      send_bits(32'h3FFFFF, LEN, 1'b0);
      drain();
      chk_val("t4_frame_err", 32'(frame_err), 32'd1);
      chk_val("t4_overrun", 32'(overrun), 32'd0);

      // values around the modulus
      expq.push_back(model(PVAL + 32'd1));
      send_bits(PVAL + 32'd1, LEN, 1'b0);
      expq.push_back(model(PVAL - 32'd1));
      send_bits(PVAL - 32'd1, LEN, 1'b0);
      expq.push_back(model(PVAL));
      send_bits(PVAL, LEN, 1'b0);
      expq.push_back(model(PVAL + 32'd2));
      send_bits(PVAL + 32'd2, LEN, 1'b0);
      drain();

      // reset mid-word with a buffered word
      qready = 1'b0;
      send_bits(32'h5, 5, 1'b0);
      expq.push_back(model(32'h111));
      send_bits(32'h111, LEN, 1'b0);
      tick();
      chk_val("t6_buffered", 32'(qvalid), 32'd1);
      chk_val("t6_ferr_pre", 32'(frame_err), 32'd1);
      send_bits(32'h1234, 15, 1'b0);
      reset = 1'b0;
      #1;
      chk_val("t6_rst_qvalid", 32'(qvalid), 32'd0);
      chk_val("t6_rst_q", 32'(q), 32'd0);
      chk_val("t6_rst_ferr", 32'(frame_err), 32'd0);
      chk_val("t6_rst_overrun", 32'(overrun), 32'd0);
      expq.delete();
      @(posedge clk);
      #1;
      reset = 1'b1;
      qready = 1'b1;
      for (int i = 0; i < LEN + 4; i++) begin
         isync = 1'b0;
         is    = 1'b1;
         @(posedge clk);
         #1;
      end
      tick();
      chk_val("t6_no_sync_idle", 32'(qvalid), 32'd0);
      expq.push_back(model(32'h7));
      send_bits(32'h7, LEN, 1'b0);
      drain();
      chk_val("t6_ferr_post", 32'(frame_err), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
